// File: rtl/ahub.sv
// Two-cog hub memory arbiter: alternating 1-bit slot grants one cog per edge,
// byte/word/long accesses on a 32-bit little-endian long array.
module ahub #(
  parameter int unsigned HUB_MEM_WIDTH = 15
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic [HUB_MEM_WIDTH-1:0] hub_addr_in_0,
  input  logic                     hub_read_in_0,
  input  logic                     hub_write_in_0,
  input  logic [1:0]               hub_sz_in_0,
  input  logic [31:0]              hub_data_in_0,
  output logic [31:0]              hub_data_o_0,
  output logic                     hub_ack_o_0,
  input  logic [HUB_MEM_WIDTH-1:0] hub_addr_in_1,
  input  logic                     hub_read_in_1,
  input  logic                     hub_write_in_1,
  input  logic [1:0]               hub_sz_in_1,
  input  logic [31:0]              hub_data_in_1,
  output logic [31:0]              hub_data_o_1,
  output logic                     hub_ack_o_1
);

  localparam int unsigned IDX_W = HUB_MEM_WIDTH - 2;
  localparam int unsigned DEPTH = 1 << IDX_W;

  logic                     slot;
  logic [31:0]              mem [DEPTH];

  logic [HUB_MEM_WIDTH-1:0] sel_addr;
  logic                     sel_rd;
  logic                     sel_wr;
  logic [1:0]               sel_sz;
  logic [31:0]              sel_wdata;
  logic                     served;
  logic [IDX_W-1:0]         sel_idx;
  logic [3:0]               lane_en;
  logic [31:0]              lane_wdata;
  logic [31:0]              rd_long;
  logic [31:0]              rd_value;

  // Only the cog owning the current slot is looked at; the other is ignored.
  always_comb begin
    sel_addr  = hub_addr_in_0;
    sel_rd    = hub_read_in_0;
    sel_wr    = hub_write_in_0;
    sel_sz    = hub_sz_in_0;
    sel_wdata = hub_data_in_0;
    if (slot) begin
      sel_addr  = hub_addr_in_1;
      sel_rd    = hub_read_in_1;
      sel_wr    = hub_write_in_1;
      sel_sz    = hub_sz_in_1;
      sel_wdata = hub_data_in_1;
    end
    served  = sel_rd | sel_wr;
    sel_idx = sel_addr[HUB_MEM_WIDTH-1:2];
  end

  // Lane enables and lane-replicated write data; sz=11 falls into the long case.
  always_comb begin
    lane_en    = 4'b1111;
    lane_wdata = sel_wdata;
    case (sel_sz)
      2'b00: begin
        lane_en    = 4'b0001 << sel_addr[1:0];
        lane_wdata = {4{sel_wdata[7:0]}};
      end
      2'b01: begin
        lane_en    = sel_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{sel_wdata[15:0]}};
      end
      default: begin
        lane_en    = 4'b1111;
        lane_wdata = sel_wdata;
      end
    endcase
  end

  // Read extraction, right-justified and zero-extended; a write returns zero.
  always_comb begin
    rd_long  = mem[sel_idx];
    rd_value = rd_long;
    case (sel_sz)
      2'b00:   rd_value = {24'h0, rd_long[{sel_addr[1:0], 3'b000} +: 8]};
      2'b01:   rd_value = {16'h0, rd_long[{sel_addr[1], 4'b0000} +: 16]};
      default: rd_value = rd_long;
    endcase
    if (sel_wr) begin
      rd_value = 32'h0;
    end
  end

  // Memory has no reset; writes are suppressed while reset is held.
  always_ff @(posedge clk_in) begin
    if (!reset_in && served && sel_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en[b]) begin
          mem[sel_idx][8*b +: 8] <= lane_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      slot         <= 1'b0;
      hub_ack_o_0  <= 1'b0;
      hub_ack_o_1  <= 1'b0;
      hub_data_o_0 <= 32'h0;
      hub_data_o_1 <= 32'h0;
    end else begin
      slot        <= ~slot;
      hub_ack_o_0 <= served & ~slot;
      hub_ack_o_1 <= served & slot;
      if (served && !slot) begin
        hub_data_o_0 <= rd_value;
      end
      if (served && slot) begin
        hub_data_o_1 <= rd_value;
      end
    end
  end

endmodule

// File: tb/tb_ahub.sv
// Self-checking bench for ahub: directed scenarios plus random accesses
// checked against a byte-addressed reference memory.
module tb_ahub;

  localparam int unsigned AW = 15;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0][AW-1:0]   addr;
  logic [1:0]           rd;
  logic [1:0]           wr;
  logic [1:0][1:0]      sz;
  logic [1:0][31:0]     wd;
  logic [31:0]          dout0, dout1;
  logic                 ack0, ack1;

  int tests = 0;
  int fails = 0;
  int ecount;
  logic [7:0] mm [int];

  ahub #(.HUB_MEM_WIDTH(AW)) dut (
    .clk_in(clk), .reset_in(rst),
    .hub_addr_in_0(addr[0]), .hub_read_in_0(rd[0]), .hub_write_in_0(wr[0]),
    .hub_sz_in_0(sz[0]), .hub_data_in_0(wd[0]), .hub_data_o_0(dout0), .hub_ack_o_0(ack0),
    .hub_addr_in_1(addr[1]), .hub_read_in_1(rd[1]), .hub_write_in_1(wr[1]),
    .hub_sz_in_1(sz[1]), .hub_data_in_1(wd[1]), .hub_data_o_1(dout1), .hub_ack_o_1(ack1)
  );

  always #5 clk = ~clk;

  // Edges since reset release: edge n (1-based) belongs to cog (n-1)%2.
  always @(posedge clk or posedge rst) begin
    if (rst) ecount <= 0;
    else     ecount <= ecount + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] s, input logic [AW-1:0] a);
    int n = nbytes(s);
    int base = int'(a) & ~(n - 1);
    logic [31:0] r = 32'h0;
    for (int i = 0; i < n; i++) r = r | (32'(mm[base + i]) << (8 * i));
    return r;
  endfunction

  task automatic model_write(input logic [1:0] s, input logic [AW-1:0] a, input logic [31:0] d);
    int n = nbytes(s);
    int base = int'(a) & ~(n - 1);
    for (int i = 0; i < n; i++) mm[base + i] = 8'(d >> (8 * i));
  endtask

  function automatic logic get_ack(input int c);
    return (c == 0) ? ack0 : ack1;
  endfunction

  function automatic logic [31:0] get_dout(input int c);
    return (c == 0) ? dout0 : dout1;
  endfunction

  // Issue one request, wait (bounded) for its ack, drop it, check latency.
  task automatic access(input int cog, input bit r, input bit w, input logic [1:0] s,
                        input logic [AW-1:0] a, input logic [31:0] d,
                        output logic [31:0] q);
    int exp_lat;
    int lat;
    exp_lat = ((ecount % 2) == cog) ? 1 : 2;
    addr[cog] = a; sz[cog] = s; wd[cog] = d; rd[cog] = r; wr[cog] = w;
    lat = 0;
    q = 32'h0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      check("single_ack", 32'(ack0 & ack1), 32'h0);
      if (get_ack(cog)) begin
        lat = i;
        q = get_dout(cog);
        break;
      end
    end
    rd[cog] = 1'b0;
    wr[cog] = 1'b0;
    check("latency", 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    logic [31:0] q;
    logic [31:0] last0;
    int cog, op;
    logic [1:0] s;
    logic [AW-1:0] a;
    logic [31:0] d;

    rd = '0; wr = '0; addr = '0; sz = '0; wd = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack0", 32'(ack0), 32'h0);
    check("rst_ack1", 32'(ack1), 32'h0);
    check("rst_dout0", dout0, 32'h0);
    check("rst_dout1", dout1, 32'h0);

    // Long write/read; first edge after release serves cog 0
    @(negedge clk); rst = 1'b0;
    access(0, 1'b0, 1'b1, 2'b10, AW'('h10), 32'hDEADBEEF, q);
    model_write(2'b10, AW'('h10), 32'hDEADBEEF);
    access(0, 1'b1, 1'b0, 2'b10, AW'('h10), 32'h0, q);
    check("long_rd", q, 32'hDEADBEEF);

    // Byte merge
    access(1, 1'b0, 1'b1, 2'b00, AW'('h12), 32'h00000055, q);
    model_write(2'b00, AW'('h12), 32'h55);
    access(0, 1'b1, 1'b0, 2'b10, AW'('h10), 32'h0, q);
    check("byte_merge", q, 32'hDE55BEEF);
    access(1, 1'b1, 1'b0, 2'b00, AW'('h13), 32'h0, q);
    check("byte_rd", q, 32'h000000DE);
    access(1, 1'b1, 1'b0, 2'b01, AW'('h13), 32'h0, q);
    check("word_rd_hi", q, 32'h0000DE55);

    // Word alignment ignores addr[0]
    access(0, 1'b0, 1'b1, 2'b01, AW'('h21), 32'h00001234, q);
    access(0, 1'b1, 1'b0, 2'b10, AW'('h20), 32'h0, q);
    check("word_lanes", {16'h0, q[15:0]}, 32'h00001234);
    last0 = q;
    access(1, 1'b1, 1'b0, 2'b01, AW'('h20), 32'h0, q);
    check("word_rd", q, 32'h00001234);
    check("hold0", dout0, last0);

    // Idle slots never ack
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("idle", 32'({ack1, ack0}), 32'h0);
    end

    // Contention right after reset
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    addr[0] = AW'('h10); sz[0] = 2'b10; rd[0] = 1'b1;
    addr[1] = AW'('h10); sz[1] = 2'b10; rd[1] = 1'b1;
    @(posedge clk); #1;
    check("cont_e1", 32'({ack1, ack0}), 32'h1);
    check("cont_d0", dout0, 32'hDE55BEEF);
    rd[0] = 1'b0;
    @(posedge clk); #1;
    check("cont_e2", 32'({ack1, ack0}), 32'h2);
    check("cont_d1", dout1, 32'hDE55BEEF);
    rd[1] = 1'b0;

    // Held request is served again on the next own slot
    rd[0] = 1'b1;
    @(posedge clk); #1;
    check("hold_e3", 32'({ack1, ack0}), 32'h1);
    @(posedge clk); #1;
    check("hold_e4", 32'({ack1, ack0}), 32'h0);
    @(posedge clk); #1;
    check("hold_e5", 32'({ack1, ack0}), 32'h1);
    rd[0] = 1'b0;

    // Simultaneous read+write performs the write only
    access(1, 1'b1, 1'b1, 2'b10, AW'('h40), 32'hA5A5A5A5, q);
    model_write(2'b10, AW'('h40), 32'hA5A5A5A5);
    check("rw_zero", q, 32'h0);
    access(0, 1'b1, 1'b0, 2'b10, AW'('h40), 32'h0, q);
    check("rw_rd", q, 32'hA5A5A5A5);

    // Reset asserted at a cog-0 write serving edge
    @(negedge clk);
    if ((ecount % 2) != 0) @(negedge clk);
    addr[0] = AW'('h10); sz[0] = 2'b10; wd[0] = 32'h11111111; wr[0] = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstmid_ack", 32'({ack1, ack0}), 32'h0);
    check("rstmid_d0", dout0, 32'h0);
    check("rstmid_d1", dout1, 32'h0);
    wr[0] = 1'b0;
    @(negedge clk);
    addr[0] = AW'('h10); sz[0] = 2'b10; rd[0] = 1'b1;
    addr[1] = AW'('h40); sz[1] = 2'b10; rd[1] = 1'b1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_grant", 32'({ack1, ack0}), 32'h1);
    check("mem_kept", dout0, 32'hDE55BEEF);
    rd[0] = 1'b0;
    @(posedge clk); #1;
    check("post_rst_cog1", 32'({ack1, ack0}), 32'h2);
    check("mem_kept1", dout1, 32'hA5A5A5A5);
    rd[1] = 1'b0;

    // Random traffic over a pre-filled region
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      a = AW'(32'h100 + 32'(4 * i));
      access(int'($urandom_range(0, 1)), 1'b0, 1'b1, 2'b10, a, d, q);
      model_write(2'b10, a, d);
    end
    for (int i = 0; i < 300; i++) begin
      cog = int'($urandom_range(0, 1));
      op  = int'($urandom_range(0, 2));
      s   = 2'($urandom_range(0, 3));
      a   = AW'(32'h100 + $urandom_range(0, 63));
      d   = $urandom;
      access(cog, op != 1, op != 0, s, a, d, q);
      if (op == 0) check("rand_rd", q, model_read(s, a));
      else if (op == 2) check("rand_rw", q, 32'h0);
      if (op != 0) model_write(s, a, d);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ahub.md
AHUB -- requirements
Module: ahub

Interface
REQ-001 SHALL provide parameter HUB_MEM_WIDTH, default 15, meaning byte-address width of hub memory (2^(HUB_MEM_WIDTH-2) longs).
REQ-002 SHALL provide port clk_in, input, 1, single clock for all logic; rising edge.
REQ-003 SHALL provide port reset_in, input, 1, reset, asynchronous, active-high.
REQ-004 SHALL provide per cog k in {0,1}: hub_addr_in_k, input, HUB_MEM_WIDTH, byte address.
REQ-005 SHALL provide hub_read_in_k, input, 1, read request level, held until ack.
REQ-006 SHALL provide hub_write_in_k, input, 1, write request level, held until ack.
REQ-007 SHALL provide hub_sz_in_k, input, 2, size: 00 byte, 01 word, 10 long, 11 long.
REQ-008 SHALL provide hub_data_in_k, input, 32, write data, right-justified.
REQ-009 SHALL provide hub_data_o_k, output, 32, read data, right-justified, zero-extended.
REQ-010 SHALL provide hub_ack_o_k, output, 1, one-cycle completion pulse.

Function
REQ-011 SHALL hold a 1-bit slot register toggling every clock: 0 -> 1 -> 0 ...; slot k grants cog k only.
REQ-012 SHALL, at a rising edge with slot==k and cog k read or write asserted, perform exactly one access for cog k; the other cog is not sampled that edge.
REQ-013 SHALL assert hub_ack_o_k for exactly the one cycle following the serving edge; ack deasserts at the next edge unconditionally.
REQ-014 SHALL present read data on hub_data_o_k in the same cycle as hub_ack_o_k and hold it until the next access served for cog k.
REQ-015 SHALL give access latency of 1 cycle from serving edge to ack; worst-case request-to-ack 2 cycles (request arriving just after its slot).
REQ-016 SHALL, if a cog keeps its request asserted after ack, serve it again at its next slot (cog is responsible for dropping the request on ack).
REQ-017 SHALL store memory as 32-bit longs indexed by addr[HUB_MEM_WIDTH-1:2], little-endian byte lanes selected by addr[1:0].
REQ-018 SHALL for byte size use lane addr[1:0]; for word size ignore addr[0] and use lanes {addr[1],0} and {addr[1],1}; for long size ignore addr[1:0].
REQ-019 SHALL on byte/word write modify only the addressed lanes, other lanes of the long unchanged.
REQ-020 SHALL on byte/word read return lane data in hub_data_o_k[7:0] / [15:0] with upper bits zero.
REQ-021 SHALL, when read and write both asserted for the served cog, perform the write only and return hub_data_o_k = 32'h0 with ack.
REQ-022 SHALL give read-after-write coherence: a read served at any edge after a write's serving edge returns the written data (either cog).
REQ-023 SHALL never ack a cog with neither read nor write asserted at its serving edge; that slot is idle.
REQ-024 SHALL treat sz=11 identically to sz=10.

Reset
REQ-025 SHALL on reset_in high immediately force slot=0, hub_ack_o_0=hub_ack_o_1=0, hub_data_o_0=hub_data_o_1=32'h0.
REQ-026 SHALL perform no memory write on any edge while reset_in is high; an access in flight when reset asserts is dropped without ack.
REQ-027 SHALL leave memory contents unchanged by reset (no initialisation).
REQ-028 SHALL make first slot after reset release cog 0 (first rising edge with reset_in low serves cog 0).

Verification
REQ-029 Long write/read: cog0 write addr 0x0010 sz=10 data 0xDEADBEEF, then read sz=10 -> ack 1 cycle after slot-0 edge, read data 0xDEADBEEF.
REQ-030 Byte merge: after REQ-029, cog1 write addr 0x0012 sz=00 data 0x55, read long 0x0010 -> 0xDE55BEEF; byte read 0x0013 -> 0x000000DE.
REQ-031 Word alignment: write word addr 0x0021 data 0x1234 -> long at 0x0020 lanes[15:0]=0x1234; word read 0x0020 -> 0x00001234.
REQ-032 Contention: both cogs request on same cycle after reset -> cog0 ack cycle N+1, cog1 ack cycle N+2, never both acks high together.
REQ-033 Simultaneous read+write: cog1 read=write=1 addr 0x0040 data 0xA5A5A5A5 -> ack with data_o 0x0; subsequent read returns 0xA5A5A5A5.
REQ-034 Reset mid-operation: assert reset_in in cycle of cog0 write serving edge -> no ack, memory location unchanged, outputs 0, first post-reset grant to cog0.
